// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: carries decoded controls and operands into EX,
// with flush, bubble and hold control plus a saturating bubble counter.
module id_ex_stage #(
  parameter int                  ALUSEL_W   = 3,
  parameter int                  ALUOP_W    = 8,
  parameter int                  DATA_W     = 32,
  parameter int                  ADDR_W     = 5,
  parameter int                  CNT_W      = 16,
  parameter logic [ALUSEL_W-1:0] NOP_ALUSEL = {ALUSEL_W{1'b0}},
  parameter logic [ALUOP_W-1:0]  NOP_ALUOP  = {ALUOP_W{1'b0}}
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [5:0]          stall,
  input  logic                flush,
  input  logic                cnt_clr,
  input  logic                id_valid,
  input  logic [ALUSEL_W-1:0] id_alusel,
  input  logic [ALUOP_W-1:0]  id_aluop,
  input  logic [DATA_W-1:0]   id_reg1,
  input  logic [DATA_W-1:0]   id_reg2,
  input  logic [ADDR_W-1:0]   id_wd,
  input  logic                id_wreg,
  input  logic [DATA_W-1:0]   id_link_address,
  input  logic                id_is_in_delayslot,
  input  logic                next_inst_in_delayslot_i,
  input  logic [DATA_W-1:0]   id_inst,
  input  logic [DATA_W-1:0]   id_current_inst_address,
  input  logic [DATA_W-1:0]   id_excepttype,
  output logic                ex_valid,
  output logic [ALUSEL_W-1:0] ex_alusel,
  output logic [ALUOP_W-1:0]  ex_aluop,
  output logic [DATA_W-1:0]   ex_reg1,
  output logic [DATA_W-1:0]   ex_reg2,
  output logic [ADDR_W-1:0]   ex_wd,
  output logic                ex_wreg,
  output logic [DATA_W-1:0]   ex_link_address,
  output logic                ex_is_in_delayslot,
  output logic [DATA_W-1:0]   ex_inst,
  output logic [DATA_W-1:0]   ex_current_inst_address,
  output logic [DATA_W-1:0]   ex_excepttype,
  output logic                is_in_delayslot_o,
  output logic [CNT_W-1:0]    bubble_cnt
);

  typedef struct packed {
    logic                valid;
    logic [ALUSEL_W-1:0] alusel;
    logic [ALUOP_W-1:0]  aluop;
    logic [DATA_W-1:0]   reg1;
    logic [DATA_W-1:0]   reg2;
    logic [ADDR_W-1:0]   wd;
    logic                wreg;
    logic [DATA_W-1:0]   link_address;
    logic                is_in_delayslot;
    logic [DATA_W-1:0]   inst;
    logic [DATA_W-1:0]   pc;
    logic [DATA_W-1:0]   excepttype;
  } ex_t;

  function automatic ex_t nop_set();
    ex_t n;
    n        = '0;
    n.alusel = NOP_ALUSEL;
    n.aluop  = NOP_ALUOP;
    return n;
  endfunction

  ex_t              id_s;
  ex_t              ex_d, ex_q;
  logic             ds_d, ds_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic             bubble_s;
  logic             unused_stall_s;

  assign id_s = {id_valid, id_alusel, id_aluop, id_reg1, id_reg2, id_wd, id_wreg,
                 id_link_address, id_is_in_delayslot, id_inst,
                 id_current_inst_address, id_excepttype};

  // Only the ID and EX stall bits matter to this stage.
  assign unused_stall_s = ^{stall[5:4], stall[1:0]};
  assign bubble_s       = ~flush & stall[2] & ~stall[3];

  // Next-state selection: flush > bubble > hold > advance.
  always_comb begin
    ex_d = ex_q;
    ds_d = ds_q;
    if (flush) begin
      ex_d = nop_set();
      ds_d = 1'b0;
    end else if (bubble_s) begin
      ex_d = nop_set();
      ds_d = ds_q;
    end else if (stall[3]) begin
      ex_d = ex_q;
      ds_d = ds_q;
    end else begin
      ex_d = id_s;
      ds_d = next_inst_in_delayslot_i;
    end
  end

  // Bubble counter: saturating increment, clear wins.
  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clr) begin
      cnt_d = {CNT_W{1'b0}};
    end else if (bubble_s && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // State registers with asynchronous active-low reset to the NOP set.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ex_q  <= nop_set();
      ds_q  <= 1'b0;
      cnt_q <= {CNT_W{1'b0}};
    end else begin
      ex_q  <= ex_d;
      ds_q  <= ds_d;
      cnt_q <= cnt_d;
    end
  end

  assign ex_valid                = ex_q.valid;
  assign ex_alusel               = ex_q.alusel;
  assign ex_aluop                = ex_q.aluop;
  assign ex_reg1                 = ex_q.reg1;
  assign ex_reg2                 = ex_q.reg2;
  assign ex_wd                   = ex_q.wd;
  assign ex_wreg                 = ex_q.wreg;
  assign ex_link_address         = ex_q.link_address;
  assign ex_is_in_delayslot      = ex_q.is_in_delayslot;
  assign ex_inst                 = ex_q.inst;
  assign ex_current_inst_address = ex_q.pc;
  assign ex_excepttype           = ex_q.excepttype;
  assign is_in_delayslot_o       = ds_q;
  assign bubble_cnt              = cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage; a second instance with CNT_W=2 checks saturation.
`timescale 1ns/1ps
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  stall;
  logic        flush, cnt_clr;
  logic        id_valid;
  logic [2:0]  id_alusel;
  logic [7:0]  id_aluop;
  logic [31:0] id_reg1, id_reg2, id_link_address, id_inst, id_pc, id_exc;
  logic [4:0]  id_wd;
  logic        id_wreg, id_is_in_delayslot, next_ds;

  logic        ex_valid, ex_wreg, ex_is_in_delayslot, ds_o;
  logic [2:0]  ex_alusel;
  logic [7:0]  ex_aluop;
  logic [31:0] ex_reg1, ex_reg2, ex_link_address, ex_inst, ex_pc, ex_exc;
  logic [4:0]  ex_wd;
  logic [15:0] bubble_cnt;

  logic        s_valid, s_wreg, s_is_ds, s_ds_o;
  logic [2:0]  s_alusel;
  logic [7:0]  s_aluop;
  logic [31:0] s_reg1, s_reg2, s_link, s_inst, s_pc, s_exc;
  logic [4:0]  s_wd;
  logic [1:0]  s_cnt;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .cnt_clr(cnt_clr),
    .id_valid(id_valid), .id_alusel(id_alusel), .id_aluop(id_aluop),
    .id_reg1(id_reg1), .id_reg2(id_reg2), .id_wd(id_wd), .id_wreg(id_wreg),
    .id_link_address(id_link_address), .id_is_in_delayslot(id_is_in_delayslot),
    .next_inst_in_delayslot_i(next_ds), .id_inst(id_inst),
    .id_current_inst_address(id_pc), .id_excepttype(id_exc),
    .ex_valid(ex_valid), .ex_alusel(ex_alusel), .ex_aluop(ex_aluop),
    .ex_reg1(ex_reg1), .ex_reg2(ex_reg2), .ex_wd(ex_wd), .ex_wreg(ex_wreg),
    .ex_link_address(ex_link_address), .ex_is_in_delayslot(ex_is_in_delayslot),
    .ex_inst(ex_inst), .ex_current_inst_address(ex_pc), .ex_excepttype(ex_exc),
    .is_in_delayslot_o(ds_o), .bubble_cnt(bubble_cnt)
  );

  id_ex_stage #(.CNT_W(2)) dut_small (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .cnt_clr(cnt_clr),
    .id_valid(id_valid), .id_alusel(id_alusel), .id_aluop(id_aluop),
    .id_reg1(id_reg1), .id_reg2(id_reg2), .id_wd(id_wd), .id_wreg(id_wreg),
    .id_link_address(id_link_address), .id_is_in_delayslot(id_is_in_delayslot),
    .next_inst_in_delayslot_i(next_ds), .id_inst(id_inst),
    .id_current_inst_address(id_pc), .id_excepttype(id_exc),
    .ex_valid(s_valid), .ex_alusel(s_alusel), .ex_aluop(s_aluop),
    .ex_reg1(s_reg1), .ex_reg2(s_reg2), .ex_wd(s_wd), .ex_wreg(s_wreg),
    .ex_link_address(s_link), .ex_is_in_delayslot(s_is_ds),
    .ex_inst(s_inst), .ex_current_inst_address(s_pc), .ex_excepttype(s_exc),
    .is_in_delayslot_o(s_ds_o), .bubble_cnt(s_cnt)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_id(input logic v, input logic [7:0] op, input logic [31:0] r1,
                         input logic [31:0] r2, input logic [4:0] wd, input logic ds,
                         input logic nds);
    id_valid = v;  id_alusel = 3'd1; id_aluop = op; id_reg1 = r1; id_reg2 = r2;
    id_wd = wd; id_wreg = 1'b1; id_link_address = r1 ^ 32'h0000_0100;
    id_is_in_delayslot = ds; next_ds = nds;
    id_inst = r2 ^ 32'h5A5A_5A5A; id_pc = 32'h0000_0400; id_exc = 32'h0000_0200;
  endtask

  task automatic test_reset();
    rst = 1'b0; stall = 6'd0; flush = 1'b0; cnt_clr = 1'b0;
    load_id(1'b1, 8'hFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd31, 1'b1, 1'b1);
    step(); step();
    checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0h exp 0", ex_valid); end
    checks++; if (ex_aluop !== 8'h00 || ex_alusel !== 3'd0) begin errors++; $display("FAIL reset_alu got %h/%h exp 00/0", ex_aluop, ex_alusel); end
    checks++; if ({ex_reg1, ex_reg2, ex_inst, ex_pc, ex_exc, ex_link_address} !== 192'd0) begin errors++; $display("FAIL reset_data got nonzero exp 0"); end
    checks++; if (ds_o !== 1'b0 || bubble_cnt !== 16'd0 || ex_wreg !== 1'b0 || ex_wd !== 5'd0) begin errors++; $display("FAIL reset_misc got ds=%0b cnt=%0d wreg=%0b wd=%0d exp 0", ds_o, bubble_cnt, ex_wreg, ex_wd); end
    rst = 1'b1;
  endtask

  task automatic test_advance();
    stall = 6'd0;
    load_id(1'b1, 8'h21, 32'h1234_5678, 32'hCAFE_BABE, 5'd5, 1'b0, 1'b0);
    step();
    checks++; if (ex_valid !== 1'b1 || ex_aluop !== 8'h21 || ex_alusel !== 3'd1) begin errors++; $display("FAIL adv_ctl got v=%0b op=%h sel=%0d exp 1/21/1", ex_valid, ex_aluop, ex_alusel); end
    checks++; if (ex_reg1 !== 32'h1234_5678 || ex_reg2 !== 32'hCAFE_BABE) begin errors++; $display("FAIL adv_ops got %h %h exp 12345678 cafebabe", ex_reg1, ex_reg2); end
    checks++; if (ex_wd !== 5'd5 || ex_wreg !== 1'b1) begin errors++; $display("FAIL adv_dst got %0d/%0b exp 5/1", ex_wd, ex_wreg); end
    checks++; if (ex_link_address !== 32'h1234_5778 || ex_inst !== 32'h90A4_E0E4 || ex_pc !== 32'h0000_0400 || ex_exc !== 32'h0000_0200) begin errors++; $display("FAIL adv_data got %h %h %h %h", ex_link_address, ex_inst, ex_pc, ex_exc); end
  endtask

  task automatic test_bubble();
    stall = 6'b000111;
    repeat (3) step();
    checks++; if (ex_valid !== 1'b0 || ex_wreg !== 1'b0 || ex_aluop !== 8'h00 || ex_reg1 !== 32'd0) begin errors++; $display("FAIL bubble_nop got v=%0b w=%0b op=%h r1=%h exp 0", ex_valid, ex_wreg, ex_aluop, ex_reg1); end
    checks++; if (bubble_cnt !== 16'd3) begin errors++; $display("FAIL bubble_cnt got %0d exp 3", bubble_cnt); end
    checks++; if (s_cnt !== 2'd3) begin errors++; $display("FAIL bubble_cnt_small got %0d exp 3", s_cnt); end
  endtask

  task automatic test_hold();
    stall = 6'd0;
    load_id(1'b1, 8'h33, 32'hAAAA_0001, 32'hBBBB_0002, 5'd9, 1'b0, 1'b1);
    step();
    stall = 6'b001111;
    load_id(1'b0, 8'h44, 32'h1111_1111, 32'h2222_2222, 5'd1, 1'b1, 1'b0);
    step();
    load_id(1'b1, 8'h55, 32'h3333_3333, 32'h4444_4444, 5'd2, 1'b1, 1'b0);
    step();
    checks++; if (ex_valid !== 1'b1 || ex_aluop !== 8'h33 || ex_reg1 !== 32'hAAAA_0001 || ex_wd !== 5'd9) begin errors++; $display("FAIL hold_data got v=%0b op=%h r1=%h wd=%0d exp 1/33/aaaa0001/9", ex_valid, ex_aluop, ex_reg1, ex_wd); end
    checks++; if (ds_o !== 1'b1 || bubble_cnt !== 16'd3) begin errors++; $display("FAIL hold_ds_cnt got ds=%0b cnt=%0d exp 1/3", ds_o, bubble_cnt); end
    stall = 6'b001000;  // stall[3] without stall[2] behaves as hold
    step();
    checks++; if (ex_aluop !== 8'h33 || ex_reg2 !== 32'hBBBB_0002 || bubble_cnt !== 16'd3) begin errors++; $display("FAIL hold_illegal got op=%h r2=%h cnt=%0d exp 33/bbbb0002/3", ex_aluop, ex_reg2, bubble_cnt); end
  endtask

  task automatic test_flush();
    stall = 6'b001111; flush = 1'b1;
    step();
    flush = 1'b0;
    checks++; if (ex_valid !== 1'b0 || ex_aluop !== 8'h00 || ex_reg1 !== 32'd0 || ex_wd !== 5'd0 || ex_inst !== 32'd0) begin errors++; $display("FAIL flush_nop got v=%0b op=%h r1=%h wd=%0d", ex_valid, ex_aluop, ex_reg1, ex_wd); end
    checks++; if (ds_o !== 1'b0 || bubble_cnt !== 16'd3) begin errors++; $display("FAIL flush_ds_cnt got ds=%0b cnt=%0d exp 0/3", ds_o, bubble_cnt); end
  endtask

  task automatic test_delayslot();
    stall = 6'd0;
    load_id(1'b1, 8'h07, 32'h0000_00AA, 32'h0000_00BB, 5'd3, 1'b0, 1'b1);
    step();
    checks++; if (ds_o !== 1'b1 || ex_is_in_delayslot !== 1'b0) begin errors++; $display("FAIL ds_advance got o=%0b ex=%0b exp 1/0", ds_o, ex_is_in_delayslot); end
    stall = 6'b000100; next_ds = 1'b0;
    step();
    checks++; if (ds_o !== 1'b1 || ex_valid !== 1'b0) begin errors++; $display("FAIL ds_bubble got o=%0b v=%0b exp 1/0", ds_o, ex_valid); end
    checks++; if (bubble_cnt !== 16'd4 || s_cnt !== 2'd3) begin errors++; $display("FAIL ds_sat got %0d/%0d exp 4/3", bubble_cnt, s_cnt); end
    stall = 6'd0;
    load_id(1'b1, 8'h08, 32'h0000_00CC, 32'h0000_00DD, 5'd4, 1'b1, 1'b0);
    step();
    checks++; if (ex_is_in_delayslot !== 1'b1 || ds_o !== 1'b0) begin errors++; $display("FAIL ds_copy got ex=%0b o=%0b exp 1/0", ex_is_in_delayslot, ds_o); end
  endtask

  task automatic test_counter();
    stall = 6'd0; cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
    checks++; if (bubble_cnt !== 16'd0 || s_cnt !== 2'd0) begin errors++; $display("FAIL cnt_clear got %0d/%0d exp 0/0", bubble_cnt, s_cnt); end
    stall = 6'b110100;
    repeat (5) step();
    checks++; if (bubble_cnt !== 16'd5 || s_cnt !== 2'd3) begin errors++; $display("FAIL cnt_five got %0d/%0d exp 5/3", bubble_cnt, s_cnt); end
    cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
    checks++; if (bubble_cnt !== 16'd0 || s_cnt !== 2'd0) begin errors++; $display("FAIL cnt_clr_bubble got %0d/%0d exp 0/0", bubble_cnt, s_cnt); end
    step();
    checks++; if (bubble_cnt !== 16'd1 || s_cnt !== 2'd1) begin errors++; $display("FAIL cnt_restart got %0d/%0d exp 1/1", bubble_cnt, s_cnt); end
  endtask

  task automatic test_async_reset();
    stall = 6'd0;
    load_id(1'b1, 8'h99, 32'hFEED_0001, 32'hFEED_0002, 5'd7, 1'b0, 1'b1);
    step();
    stall = 6'b001100;
    #2 rst = 1'b0;
    #1;
    checks++; if (ex_valid !== 1'b0 || ex_aluop !== 8'h00 || ex_reg1 !== 32'd0 || ds_o !== 1'b0 || bubble_cnt !== 16'd0) begin errors++; $display("FAIL async_rst got v=%0b op=%h r1=%h ds=%0b cnt=%0d exp 0", ex_valid, ex_aluop, ex_reg1, ds_o, bubble_cnt); end
    stall = 6'd0;
    step();
    checks++; if (ex_valid !== 1'b0 || ex_reg1 !== 32'd0) begin errors++; $display("FAIL rst_ignore got v=%0b r1=%h exp 0/0", ex_valid, ex_reg1); end
    rst = 1'b1;
    step();
    checks++; if (ex_valid !== 1'b1 || ex_reg1 !== 32'hFEED_0001 || ds_o !== 1'b1) begin errors++; $display("FAIL rst_release got v=%0b r1=%h ds=%0b exp 1/feed0001/1", ex_valid, ex_reg1, ds_o); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_r1;
    stall = 6'd0;
    for (int i = 0; i < 4; i++) begin
      exp_r1 = 32'h0100_0000 + 32'(i);
      load_id(1'b1, 8'(8'h40 + i), exp_r1, 32'h0, 5'(i + 10), 1'b0, 1'b0);
      step();
      checks++; if (ex_reg1 !== exp_r1 || ex_aluop !== 8'(8'h40 + i) || ex_wd !== 5'(i + 10)) begin errors++; $display("FAIL b2b_%0d got r1=%h op=%h wd=%0d exp %h", i, ex_reg1, ex_aluop, ex_wd, exp_r1); end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_advance();
    test_bubble();
    test_hold();
    test_flush();
    test_delayslot();
    test_counter();
    test_async_reset();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
